sram_ctl_s3board: RTL and testbench

Synchronous controller for the board's external SRAM: two 256Kx16 asynchronous chips sharing address, OE and WE, used side by side as one 256Kx32 word store. It takes single-word read/write requests from the memory-side bus master and produces the registered, glitch-free SRAM pin activity that the SRAM pair consumes. It is the stage directly upstream of the SRAM pins: this block drives them, the SRAM pair answers.

---
 rtl/sram_ctl_s3board.sv | 160 ++++++++++++++++
 tb/tb_sram_ctl_s3board.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctl_s3board.sv
// Single-word controller for the two 256Kx16 asynchronous SRAMs used side by side as 256Kx32.
// Every SRAM pin, including the io tristate enable, is driven straight from a flop.
module sram_ctl_s3board #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        wr,
    input  logic [17:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic [17:0] ram_a,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    inout  wire  [15:0] ram1_io,
    inout  wire  [15:0] ram2_io,
    output logic        ram1_ce_n,
    output logic        ram1_ub_n,
    output logic        ram1_lb_n,
    output logic        ram2_ce_n,
    output logic        ram2_ub_n,
    output logic        ram2_lb_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic        load_cnt;
    logic        drive;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [3:0]  be_sel;

    logic oe_d, we_d, ce1_d, ub1_d, lb1_d, ce2_d, ub2_d, lb2_d;
    logic drive_d, ack_d, busy_d;

    assign ram1_io = drive ? wdata_q[15:0]  : 16'hzzzz;
    assign ram2_io = drive ? wdata_q[31:16] : 16'hzzzz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (load_cnt) begin
                cnt <= 4'(WAIT_CYCLES - 1);
            end else if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (req) state_next = wr ? WR_SETUP : RD;
            RD:       if (cnt == 4'd0) state_next = RD_DONE;
            RD_DONE:  state_next = IDLE;
            WR_SETUP: state_next = WR_PULSE;
            WR_PULSE: if (cnt == 4'd0) state_next = WR_HOLD;
            WR_HOLD:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        load_cnt = (state_next == RD && state != RD) ||
                   (state_next == WR_PULSE && state != WR_PULSE);
    end

    // Pin values for the coming cycle; on the accept edge the lanes come from the live be input.
    always_comb begin
        be_sel  = (state == IDLE) ? be : be_q;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        ce1_d   = 1'b1;
        ub1_d   = 1'b1;
        lb1_d   = 1'b1;
        ce2_d   = 1'b1;
        ub2_d   = 1'b1;
        lb2_d   = 1'b1;
        drive_d = 1'b0;
        ack_d   = (state_next == RD_DONE) || (state_next == WR_HOLD);
        busy_d  = (state_next != IDLE);
        case (state_next)
            RD: begin
                oe_d  = 1'b0;
                ce1_d = 1'b0;
                ub1_d = 1'b0;
                lb1_d = 1'b0;
                ce2_d = 1'b0;
                ub2_d = 1'b0;
                lb2_d = 1'b0;
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                drive_d = 1'b1;
                we_d    = (state_next != WR_PULSE);
                lb1_d   = ~be_sel[0];
                ub1_d   = ~be_sel[1];
                lb2_d   = ~be_sel[2];
                ub2_d   = ~be_sel[3];
                ce1_d   = ~(be_sel[0] | be_sel[1]);
                ce2_d   = ~(be_sel[2] | be_sel[3]);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_oe_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram1_ce_n <= 1'b1;
            ram1_ub_n <= 1'b1;
            ram1_lb_n <= 1'b1;
            ram2_ce_n <= 1'b1;
            ram2_ub_n <= 1'b1;
            ram2_lb_n <= 1'b1;
            drive     <= 1'b0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            ram_a     <= '0;
            rdata     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            ram_oe_n  <= oe_d;
            ram_we_n  <= we_d;
            ram1_ce_n <= ce1_d;
            ram1_ub_n <= ub1_d;
            ram1_lb_n <= lb1_d;
            ram2_ce_n <= ce2_d;
            ram2_ub_n <= ub2_d;
            ram2_lb_n <= lb2_d;
            drive     <= drive_d;
            ack       <= ack_d;
            busy      <= busy_d;
            if (state == IDLE && req) begin
                ram_a   <= addr;
                wdata_q <= wdata;
                be_q    <= be;
            end
            if (state == RD && cnt == 4'd0) begin
                rdata <= {ram2_io, ram1_io};
            end
        end
    end

endmodule

// File: tb/tb_sram_ctl_s3board.sv
// Scoreboard bench: two controller instances (WAIT_CYCLES 1 and 3), each with its own SRAM pair model,
// a word-level reference memory, a stimulus process and an ack-driven monitor.
module tb_sram_ctl_s3board;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    typedef struct {
        bit          rd;
        logic [17:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          ack_cyc;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m[i] ? nw[i*8 +: 8] : old[i*8 +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int W = (g == 0) ? 1 : 3;

        logic        reset_n, req, wr;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        ack, busy;
        logic [17:0] ram_a;
        logic        oe_n, we_n, ce1, ub1, lb1, ce2, ub2, lb2;
        wire  [15:0] io1, io2;

        logic [15:0] mem1 [int];
        logic [15:0] mem2 [int];
        logic [15:0] rd1, rd2;
        logic [31:0] ref_mem [int];
        exp_t        q [$];
        exp_t        e;
        int          contention = 0;
        int          pulse_len  = 0;

        sram_ctl_s3board #(.WAIT_CYCLES(W)) dut (
            .clk(clk), .reset_n(reset_n), .req(req), .wr(wr), .addr(addr),
            .wdata(wdata), .be(be), .rdata(rdata), .ack(ack), .busy(busy),
            .ram_a(ram_a), .ram_oe_n(oe_n), .ram_we_n(we_n),
            .ram1_io(io1), .ram2_io(io2),
            .ram1_ce_n(ce1), .ram1_ub_n(ub1), .ram1_lb_n(lb1),
            .ram2_ce_n(ce2), .ram2_ub_n(ub2), .ram2_lb_n(lb2)
        );

        // Released buses float to distinct known levels so a released bus is recognisable.
        for (genvar b = 0; b < 16; b++) begin : pulls
            pullup   (io1[b]);
            pulldown (io2[b]);
        end

        assign io1 = (ce1 == 1'b0 && oe_n == 1'b0 && we_n == 1'b1) ? rd1 : 16'hzzzz;
        assign io2 = (ce2 == 1'b0 && oe_n == 1'b0 && we_n == 1'b1) ? rd2 : 16'hzzzz;

        always @(ram_a or oe_n or ce1 or ce2 or we_n) begin
            rd1 = mem1.exists(int'(ram_a)) ? mem1[int'(ram_a)] : 16'h0000;
            rd2 = mem2.exists(int'(ram_a)) ? mem2[int'(ram_a)] : 16'h0000;
        end

        always @(posedge we_n) begin
            logic [15:0] old;
            if (ce1 === 1'b0) begin
                old = mem1.exists(int'(ram_a)) ? mem1[int'(ram_a)] : 16'h0000;
                mem1[int'(ram_a)] = {ub1 ? old[15:8] : io1[15:8], lb1 ? old[7:0] : io1[7:0]};
            end
            if (ce2 === 1'b0) begin
                old = mem2.exists(int'(ram_a)) ? mem2[int'(ram_a)] : 16'h0000;
                mem2[int'(ram_a)] = {ub2 ? old[15:8] : io2[15:8], lb2 ? old[7:0] : io2[7:0]};
            end
        end

        always @(negedge clk) begin
            if (oe_n === 1'b0 && {io2, io1} !== {rd2, rd1}) contention++;
            if (reset_n === 1'b1 && busy === 1'b0)
                check($sformatf("W%0d idle_io_released", W), {io1, io2}, 32'hFFFF_0000);
            if (we_n === 1'b0) begin
                pulse_len++;
                if (q.size() > 0)
                    check($sformatf("W%0d write_lanes", W), {26'd0, ce2, ub2, lb2, ce1, ub1, lb1},
                          {26'd0, ~(q[0].be[3] | q[0].be[2]), ~q[0].be[3], ~q[0].be[2],
                           ~(q[0].be[1] | q[0].be[0]), ~q[0].be[1], ~q[0].be[0]});
            end else if (pulse_len > 0) begin
                check($sformatf("W%0d we_pulse_len", W), pulse_len, W);
                pulse_len = 0;
            end
            if (ack === 1'b1) begin
                if (q.size() == 0) begin
                    check($sformatf("W%0d unexpected_ack", W), 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("W%0d ack_cycle", W), cyc, e.ack_cyc);
                    check($sformatf("W%0d ram_a_at_ack", W), {14'd0, ram_a}, {14'd0, e.addr});
                    if (e.rd) check($sformatf("W%0d rdata", W), rdata, e.data);
                end
            end
        end

        task automatic access(input bit w, input logic [17:0] a, input logic [31:0] d,
                              input logic [3:0] m, input bit keep, input bit wait_ack);
            int   n;
            exp_t x;
            logic [31:0] old;
            n = 0;
            @(negedge clk);
            while (busy !== 1'b0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check($sformatf("W%0d busy_timeout", W), 32'd1, 32'd0);
            req = 1'b1; wr = w; addr = a; wdata = d; be = m;
            old       = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
            x.rd      = !w;
            x.addr    = a;
            x.be      = m;
            x.data    = old;
            x.ack_cyc = cyc + (w ? W + 2 : W + 1);
            if (w) ref_mem[int'(a)] = merge(old, d, m);
            q.push_back(x);
            if (wait_ack) begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (ack !== 1'b1 && n < 200);
                if (n >= 200) check($sformatf("W%0d ack_timeout", W), 32'd1, 32'd0);
            end
            if (!keep) req = 1'b0;
        endtask

        task automatic reset_check(input string tag);
            check($sformatf("W%0d %s strobes", W, tag), {24'd0, oe_n, we_n, ce1, ub1, lb1, ce2, ub2, lb2}, 32'hFF);
            check($sformatf("W%0d %s io", W, tag), {io1, io2}, 32'hFFFF_0000);
            check($sformatf("W%0d %s busy_ack", W, tag), {30'd0, busy, ack}, 32'd0);
            check($sformatf("W%0d %s rdata", W, tag), rdata, 32'd0);
            check($sformatf("W%0d %s ram_a", W, tag), {14'd0, ram_a}, 32'd0);
        endtask

        task automatic abort_write(input logic [17:0] a, input logic [31:0] d);
            int n;
            access(1'b1, a, d, 4'hF, 1'b1, 1'b0);
            n = 0;
            while (we_n !== 1'b0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) check($sformatf("W%0d abort_no_pulse", W), 32'd1, 32'd0);
            #1;
            reset_n = 1'b0;
            req     = 1'b0;
            #1;
            check($sformatf("W%0d abort_we_n", W), {31'd0, we_n}, 32'd1);
            check($sformatf("W%0d abort_io", W), {io1, io2}, 32'hFFFF_0000);
            check($sformatf("W%0d abort_busy", W), {31'd0, busy}, 32'd0);
            q.delete();
            pulse_len = 0;
            ref_mem.delete(int'(a));
            @(negedge clk);
            reset_n = 1'b1;
        endtask

        initial begin
            logic [17:0] pool [6];
            pool = '{18'h00A9C, 18'h00123, 18'h3FFFF, 18'h00000, 18'h1F0F0, 18'h00124};
            reset_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
            repeat (3) @(negedge clk);
            reset_check("reset_init");
            reset_n = 1'b1;

            access(1'b1, 18'h00A9C, 32'h12345678, 4'hF, 1'b0, 1'b1);
            check($sformatf("W%0d ram1_word", W), {16'd0, mem1[int'(18'h00A9C)]}, 32'h5678);
            check($sformatf("W%0d ram2_word", W), {16'd0, mem2[int'(18'h00A9C)]}, 32'h1234);
            access(1'b0, 18'h00A9C, 32'h0, 4'h0, 1'b0, 1'b1);

            @(negedge clk);
            reset_n = 1'b0;
            #1;
            reset_check("reset_idle");
            @(negedge clk);
            reset_n = 1'b1;

            access(1'b1, 18'h00123, 32'h12345678, 4'hF, 1'b0, 1'b1);
            access(1'b1, 18'h00123, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b1);
            access(1'b0, 18'h00123, 32'h0, 4'h0, 1'b0, 1'b1);

            access(1'b1, 18'h3FFFF, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
            access(1'b0, 18'h3FFFF, 32'h0, 4'h0, 1'b0, 1'b1);

            access(1'b1, 18'h00A9C, 32'hDEADBEEF, 4'h0, 1'b0, 1'b1);
            access(1'b0, 18'h00A9C, 32'h0, 4'h0, 1'b0, 1'b1);

            abort_write(18'h00200, 32'h55AA55AA);
            access(1'b0, 18'h00123, 32'h0, 4'h0, 1'b0, 1'b1);

            for (int i = 0; i < 30; i++) begin
                access(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)], $urandom,
                       4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
            end
            req = 1'b0;
            repeat (5) @(negedge clk);
            check($sformatf("W%0d bus_contention_cycles", W), contention, 32'd0);
            check($sformatf("W%0d scoreboard_drained", W), q.size(), 32'd0);
            done_cnt++;
        end
    end

    initial begin
        int n;
        n = 0;
        while (done_cnt < 2 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt < 2) begin
            errors++;
            $display("[TB] FAIL watchdog: got %0d finished instances, expected 2", done_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
